// File: rtl/data_output_uart.sv
// Captures 16-bit words into a FIFO and sends each one as four uppercase hex chars plus a terminator on UART 8N1.
// Define DATA_OUTPUT_UART_CRLF_EN for a CR LF terminator; otherwise a single space is sent.
module data_output_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
`ifdef DATA_OUTPUT_UART_CRLF_EN
  localparam int NCHARS = 6;
`else
  localparam int NCHARS = 5;
`endif
  localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    CHAR_LAST = 3'(NCHARS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  function automatic logic [7:0] char_of(input logic [15:0] w, input logic [2:0] idx);
    logic [3:0] nib;
    logic [7:0] c;
    case (idx)
      3'd0:    nib = w[15:12];
      3'd1:    nib = w[11:8];
      3'd2:    nib = w[7:4];
      3'd3:    nib = w[3:0];
      default: nib = 4'h0;
    endcase
    c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    case (idx)
`ifdef DATA_OUTPUT_UART_CRLF_EN
      3'd4:    c = 8'h0D;
      3'd5:    c = 8'h0A;
`else
      3'd4:    c = 8'h20;
`endif
      default: ;
    endcase
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      char_q, char_d;
  logic [15:0]     hold_q, hold_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic            tick, fifo_empty, pop, push;
  logic [15:0]     head;

  assign tick       = (tmr_q == TMR_LAST);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Handshake: there is no ready. A word is taken on every edge with data_valid high
  // unless the FIFO is full with no pop that cycle; then it is dropped and overflow sticks.
  assign push = data_valid && ((count_q != FULL) || pop);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    char_d  = char_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop = 1'b1; hold_d = head; char_d = 3'd0;
        shift_d = char_of(head, 3'd0); state_d = S_START;
      end
      S_START: if (tick) begin
        bit_d = 3'd0; state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        if (char_q != CHAR_LAST) begin
          char_d  = char_q + 3'd1;
          shift_d = char_of(hold_q, char_q + 3'd1);
          state_d = S_START;
        end else if (!fifo_empty) begin
          pop = 1'b1; hold_d = head; char_d = 3'd0;
          shift_d = char_of(head, 3'd0); state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered, so the line trails the FSM state by one cycle throughout.
  always_comb begin
    tx_d  = 1'b1;
    tmr_d = (state_q == S_IDLE || tick) ? '0 : tmr_q + 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= 3'd0;
      char_q   <= 3'd0;
      hold_q   <= 16'h0;
      shift_q  <= 8'h0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (data_valid && !push) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign tx       = tx_q;
  assign busy     = !fifo_empty || (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_data_output_uart.sv
// Bench for data_output_uart: random word bursts checked against a hex/ASCII model and a UART receiver.
module tb_data_output_uart;
  localparam int C = 4;
  localparam int D = 4;
`ifdef DATA_OUTPUT_UART_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 5;
`endif
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic        data_valid = 1'b0;
  logic        tx, busy, overflow;
  logic [1:0]  state_o;

  data_output_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .tx(tx), .busy(busy), .overflow(overflow), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  bit         mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: four hex digits, most significant first, then the terminator
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  task automatic expect_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hex_ascii(w[i*4 +: 4]));
`ifdef DATA_OUTPUT_UART_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  // UART receiver sampling mid-bit on falling clock edges
  initial begin : monitor
    int t0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        t0 = cyc;
        repeat (C / 2) @(negedge clk);
        check_val("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        check_val("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(b);
        rx_cyc_q.push_back(t0);
        repeat (C / 2 - 1) @(negedge clk);
      end
    end
  end

  // driver tasks
  task automatic push_burst(input logic [15:0] w[$], input int max_gap, output int first_cyc);
    int gap;
    first_cyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < w.size(); i++) begin
      data_in = w[i];
      data_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) first_cyc = cyc;
      data_valid = 1'b0;
      gap = (i < w.size() - 1) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(output int fall_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
    if (busy) check_val("idle_timeout", 32'd1, 32'd0);
    fall_cyc = cyc;
    repeat (2 * C) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input int first_cyc, input int fall_cyc, input int nwords);
    int bad;
    check_val({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    bad = 0;
    for (int i = 1; i < rx_cyc_q.size(); i++)
      if (rx_cyc_q[i] - rx_cyc_q[i-1] != FRAME) bad++;
    check_val({tag, "_frame_gap"}, 32'(bad), 32'd0);
    if (rx_cyc_q.size() > 0)
      check_val({tag, "_start_latency"}, 32'(rx_cyc_q[0] - first_cyc), 32'd2);
    check_val({tag, "_busy_fall"}, 32'(fall_cyc - first_cyc), 32'(1 + nwords * NCH * FRAME));
    rx_q.delete();
    rx_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #20;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] words[$];
    int first_cyc, fall_cyc, bad, nw;

    // reset hold while data_valid toggles
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      data_valid = i[0];
      data_in = 16'(16'h1111 * i);
      #5;
      if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) bad++;
    end
    data_valid = 1'b0;
    check_val("reset_hold_outputs", 32'(bad), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check_val("post_reset_frames", 32'(rx_q.size()), 32'd0);
    check_val("post_reset_busy", 32'(busy), 32'd0);

    // single word
`ifdef DATA_OUTPUT_UART_CRLF_EN
    words = '{16'h1A2F};
`else
    words = '{16'h00FF};
`endif
    expect_word(words[0]);
    push_burst(words, 0, first_cyc);
    wait_idle(fall_cyc);
    check_rx("single", first_cyc, fall_cyc, 1);

    // random bursts from idle
    for (int b = 0; b < 6; b++) begin
      words.delete();
      nw = int'($urandom_range(5, 1));
      for (int i = 0; i < nw; i++) begin
        words.push_back(16'($urandom));
        expect_word(words[i]);
      end
      push_burst(words, 3, first_cyc);
      wait_idle(fall_cyc);
      check_rx($sformatf("rand%0d", b), first_cyc, fall_cyc, nw);
    end
    check_val("no_overflow_yet", 32'(overflow), 32'd0);

    // back-to-back words
    words = '{16'hBEEF, 16'hCAFE};
    expect_word(16'hBEEF);
    expect_word(16'hCAFE);
    push_burst(words, 0, first_cyc);
    wait_idle(fall_cyc);
    check_rx("b2b", first_cyc, fall_cyc, 2);

    // overflow: six consecutive pushes from idle, the last is dropped
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      data_in = 16'(i);
      data_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) first_cyc = cyc;
      check_val($sformatf("overflow_edge%0d", i), 32'(overflow), 32'(i == 5));
      if (i < 5) expect_word(16'(i));
    end
    data_valid = 1'b0;
    wait_idle(fall_cyc);
    check_rx("overflow", first_cyc, fall_cyc, 5);
    check_val("overflow_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    check_val("overflow_cleared", 32'(overflow), 32'd0);

    // reset in the middle of data bit 3 of the first character
    mon_en = 1'b0;
    words = '{16'h1234, 16'h5678};
    push_burst(words, 0, first_cyc);
    repeat (17) @(posedge clk);
    #2;
    check_val("pre_reset_tx", 32'(tx), 32'd0);
    check_val("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_val("reset_tx_immediate", 32'(tx), 32'd1);
    check_val("reset_busy", 32'(busy), 32'd0);
    #20;
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("after_reset_quiet", 32'(bad), 32'd0);
    check_val("after_reset_frames", 32'(rx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
